alu_muldiv: RTL and testbench

Multi-cycle RV32IM execute unit for the core's EX stage. Combines the base integer ALU operations with the M-extension multiply/divide/remainder operations that the single-cycle ALU returns as zero. Operands and the raw instruction are accepted on a valid/ready handshake. The result is registered and held on a valid/ready output handshake.

---
 rtl/alu_muldiv.sv | 223 ++++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// alu_muldiv: RV32IM execute unit.
// Base integer ops finish at accept; M-extension multiply/divide iterate one
// bit per cycle (shift-add / restoring) and finish XLEN edges after accept.
// Results are held on a valid/ready output handshake.
module alu_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] src_A,
    input  logic [XLEN-1:0] src_B,
    input  logic [31:0]     instruction,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ALU_result,
    output logic [6:0]      opcode_out,
    output logic            busy
);

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(XLEN) + 1;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] F7_M   = 7'b0000001;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

    // Single-cycle base ALU result (R-type, OP-IMM, anything else adds).
    function automatic logic [XLEN-1:0] base_op(
        input logic [6:0]      op,
        input logic [2:0]      f3,
        input logic [6:0]      f7,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [SHW-1:0]  sh;
        logic [XLEN-1:0] r;
        sh = b[SHW-1:0];
        r  = a + b;
        if (op == OP_R || op == OP_I) begin
            case (f3)
                3'b000: begin
                    if (op == OP_R && f7[5]) r = a - b;
                    else                     r = a + b;
                end
                3'b001: begin
                    if (op == OP_R || f7 == 7'b0000000) r = a << sh;
                    else                                r = {XLEN{1'b0}};
                end
                3'b010: r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
                3'b011: r = {{(XLEN-1){1'b0}}, (a < b)};
                3'b100: r = a ^ b;
                3'b101: begin
                    // Arithmetic shift kept in its own statement so signedness survives.
                    if ((op == OP_R && f7[5]) || (op == OP_I && f7 == F7_ALT)) r = $signed(a) >>> sh;
                    else if (op == OP_R || f7 == 7'b0000000)                     r = a >> sh;
                    else                                                        r = {XLEN{1'b0}};
                end
                3'b110: r = a | b;
                3'b111: r = a & b;
                default: r = a + b;
            endcase
        end else begin
            r = a + b;
        end
        return r;
    endfunction

    state_t              state_r, state_n;
    logic [2*XLEN-1:0]   acc_r, acc_n;
    logic [XLEN-1:0]     opnd_r, opnd_n;
    logic [CW-1:0]       cnt_r, cnt_n;
    logic                neg_r, neg_n;
    logic [2:0]          f3_r, f3_n;
    logic                is_div_r, is_div_n;
    logic [XLEN-1:0]     result_r, result_n;
    logic [6:0]          opcode_r, opcode_n;

    logic [6:0]          opcode_s, funct7_s;
    logic [2:0]          funct3_s;
    logic                is_m_s, in_ready_s, accept_s;
    logic                a_signed_s, b_signed_s, a_neg_s, b_neg_s, res_neg_s;
    logic [XLEN-1:0]     mag_a_s, mag_b_s, special_s;
    logic                div_zero_s, div_ovf_s, special_case_s;
    logic [XLEN:0]       mul_sum_s, div_trial_s;
    logic [2*XLEN-1:0]   mul_step_s, div_step_s, acc_step_s, prod_fix_s;
    logic [XLEN-1:0]     div_val_s, div_fix_s, final_s;
    logic                unused_bits_s;

    assign opcode_s      = instruction[6:0];
    assign funct3_s      = instruction[14:12];
    assign funct7_s      = instruction[31:25];
    assign unused_bits_s = ^instruction[24:15] ^ ^instruction[11:7];
    assign is_m_s        = (opcode_s == OP_R) && (funct7_s == F7_M);
    assign in_ready_s    = (state_r == IDLE) || ((state_r == HOLD) && out_ready);
    assign accept_s      = in_valid && in_ready_s;

    // Operand signedness, magnitudes, result sign and divide special cases at accept.
    always_comb begin
        if (funct3_s[2]) begin
            a_signed_s = ~funct3_s[0];
            b_signed_s = ~funct3_s[0];
        end else begin
            a_signed_s = (funct3_s == 3'b001) || (funct3_s == 3'b010);
            b_signed_s = (funct3_s == 3'b001);
        end
        a_neg_s   = a_signed_s && src_A[XLEN-1];
        b_neg_s   = b_signed_s && src_B[XLEN-1];
        mag_a_s   = a_neg_s ? -src_A : src_A;
        mag_b_s   = b_neg_s ? -src_B : src_B;
        // Remainder takes the dividend's sign; everything else the product sign.
        res_neg_s = (funct3_s[2] && funct3_s[1]) ? a_neg_s : (a_neg_s ^ b_neg_s);
        div_zero_s = (src_B == {XLEN{1'b0}});
        div_ovf_s  = a_signed_s && (src_A == {1'b1, {(XLEN-1){1'b0}}}) && (src_B == {XLEN{1'b1}});
        special_case_s = funct3_s[2] && (div_zero_s || div_ovf_s);
        if (div_zero_s) special_s = funct3_s[1] ? src_A : {XLEN{1'b1}};
        else            special_s = funct3_s[1] ? {XLEN{1'b0}} : src_A;
    end

    // One shift-add or restoring-divide step, plus the final sign fix and half select.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
        mul_step_s  = {mul_sum_s, acc_r[XLEN-1:1]};
        div_trial_s = acc_r[2*XLEN-1:XLEN-1] - {1'b0, opnd_r};
        if (div_trial_s[XLEN]) div_step_s = {acc_r[2*XLEN-2:0], 1'b0};
        else                   div_step_s = {div_trial_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
        acc_step_s = is_div_r ? div_step_s : mul_step_s;
        prod_fix_s = neg_r ? -acc_step_s : acc_step_s;
        div_val_s  = f3_r[1] ? acc_step_s[2*XLEN-1:XLEN] : acc_step_s[XLEN-1:0];
        div_fix_s  = neg_r ? -div_val_s : div_val_s;
        if (is_div_r)                final_s = div_fix_s;
        else if (f3_r[1:0] == 2'b00) final_s = prod_fix_s[XLEN-1:0];
        else                         final_s = prod_fix_s[2*XLEN-1:XLEN];
    end

    // Next-state and datapath-register selection for IDLE/RUN/HOLD.
    always_comb begin
        state_n  = state_r;
        acc_n    = acc_r;
        opnd_n   = opnd_r;
        cnt_n    = cnt_r;
        neg_n    = neg_r;
        f3_n     = f3_r;
        is_div_n = is_div_r;
        result_n = result_r;
        opcode_n = opcode_r;
        case (state_r)
            IDLE, HOLD: begin
                if (accept_s) begin
                    if (is_m_s && !special_case_s) begin
                        state_n  = RUN;
                        cnt_n    = CW'(XLEN);
                        neg_n    = res_neg_s;
                        f3_n     = funct3_s;
                        is_div_n = funct3_s[2];
                        if (funct3_s[2]) begin
                            acc_n  = {{XLEN{1'b0}}, mag_a_s};
                            opnd_n = mag_b_s;
                        end else begin
                            acc_n  = {{XLEN{1'b0}}, mag_b_s};
                            opnd_n = mag_a_s;
                        end
                    end else begin
                        state_n  = HOLD;
                        result_n = is_m_s ? special_s : base_op(opcode_s, funct3_s, funct7_s, src_A, src_B);
                        opcode_n = opcode_s;
                    end
                end else if (state_r == HOLD && out_ready) begin
                    state_n = IDLE;
                end else begin
                    state_n = state_r;
                end
            end
            RUN: begin
                acc_n = acc_step_s;
                if (cnt_r == {{(CW-1){1'b0}}, 1'b1}) begin
                    state_n  = HOLD;
                    cnt_n    = {CW{1'b0}};
                    result_n = final_s;
                    opcode_n = OP_R;
                end else begin
                    cnt_n = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any operation in flight.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r  <= IDLE;
            acc_r    <= {(2*XLEN){1'b0}};
            opnd_r   <= {XLEN{1'b0}};
            cnt_r    <= {CW{1'b0}};
            neg_r    <= 1'b0;
            f3_r     <= 3'b000;
            is_div_r <= 1'b0;
            result_r <= {XLEN{1'b0}};
            opcode_r <= 7'b0000000;
        end else begin
            state_r  <= state_n;
            acc_r    <= acc_n;
            opnd_r   <= opnd_n;
            cnt_r    <= cnt_n;
            neg_r    <= neg_n;
            f3_r     <= f3_n;
            is_div_r <= is_div_n;
            result_r <= result_n;
            opcode_r <= opcode_n;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = (state_r == HOLD);
    assign busy       = (state_r == RUN);
    assign ALU_result = result_r;
    assign opcode_out = opcode_r;

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: directed vectors, a plain-arithmetic reference model,
// an expected-result queue with due cycles, and a per-cycle compare process.
module tb_alu_muldiv;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] src_A = 32'd0;
    logic [31:0] src_B = 32'd0;
    logic [31:0] instruction = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] ALU_result;
    logic [6:0]  opcode_out;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] res;
        logic [6:0]  op;
        int          due;
    } exp_t;
    exp_t q[$];

    alu_muldiv #(.XLEN(32)) dut (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
        .src_A(src_A), .src_B(src_B), .instruction(instruction),
        .out_valid(out_valid), .out_ready(out_ready), .ALU_result(ALU_result),
        .opcode_out(opcode_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 10'd0, f3, 5'd0, 7'h33};
    endfunction

    function automatic logic [31:0] i_ins(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 10'd0, f3, 5'd0, 7'h13};
    endfunction

    // Reference behaviour from the instruction set rules.
    function automatic logic [31:0] model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        logic [6:0]  op;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [4:0]  sh;
        longint      sa;
        longint      sb;
        logic [63:0] p;
        op = ins[6:0]; f7 = ins[31:25]; f3 = ins[14:12]; sh = b[4:0];
        sa = longint'($signed(a)); sb = longint'($signed(b));
        if (op == 7'h33 && f7 == 7'h01) begin
            case (f3)
                3'd0: begin p = sa * sb; return p[31:0]; end
                3'd1: begin p = sa * sb; return p[63:32]; end
                3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
                3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
                3'd4: begin
                    if (b == 32'd0) return 32'hFFFF_FFFF;
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                    return 32'(sa / sb);
                end
                3'd5: begin if (b == 32'd0) return 32'hFFFF_FFFF; return a / b; end
                3'd6: begin
                    if (b == 32'd0) return a;
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                    return 32'(sa % sb);
                end
                default: begin if (b == 32'd0) return a; return a % b; end
            endcase
        end
        if (op == 7'h33 || op == 7'h13) begin
            case (f3)
                3'd0: begin if (op == 7'h33 && f7[5]) return a - b; return a + b; end
                3'd1: begin if (op == 7'h13 && f7 != 7'h00) return 32'd0; return a << sh; end
                3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: return (a < b) ? 32'd1 : 32'd0;
                3'd4: return a ^ b;
                3'd5: begin
                    if ((op == 7'h33 && f7[5]) || (op == 7'h13 && f7 == 7'h20)) return $signed(a) >>> sh;
                    if (op == 7'h13 && f7 != 7'h00) return 32'd0;
                    return a >> sh;
                end
                3'd6: return a | b;
                default: return a & b;
            endcase
        end
        return a + b;
    endfunction

    // Cycles from the accept edge until the result should be visible.
    function automatic int latency(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        if (ins[6:0] != 7'h33 || ins[31:25] != 7'h01) return 0;
        if (ins[14] && (b == 32'd0 || (!ins[12] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 0;
        return 32;
    endfunction

    // Monitor: track edges, retire consumed results, enqueue accepted ops.
    always @(posedge clk) begin
        int  nxt;
        bit  rdy;
        nxt = cyc + 1;
        if (!n_rst) begin
            q.delete();
        end else begin
            rdy = (q.size() == 0) || (cyc >= q[0].due && out_ready);
            if (q.size() > 0 && cyc >= q[0].due && out_ready) void'(q.pop_front());
            if (in_valid && rdy)
                q.push_back('{model(instruction, src_A, src_B), instruction[6:0],
                              nxt + latency(instruction, src_A, src_B)});
        end
        cyc = nxt;
    end

    // Compare: every cycle, check all outputs against the model queue.
    always @(negedge clk) begin
        bit ev;
        if (cyc > 0) begin
            if (!n_rst) begin
                chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_result", ALU_result, 32'd0);
                chk("rst_opcode", {25'd0, opcode_out}, 32'd0);
            end else begin
                ev = (q.size() > 0) && (cyc >= q[0].due);
                chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
                chk("busy", {31'd0, busy}, {31'd0, (q.size() > 0) && !ev});
                chk("in_ready", {31'd0, in_ready}, {31'd0, (q.size() == 0) || (ev && out_ready)});
                if (ev) begin
                    chk("ALU_result", ALU_result, q[0].res);
                    chk("opcode_out", {25'd0, opcode_out}, {25'd0, q[0].op});
                end
            end
        end
    end

    // Present one op, wait for accept, then scramble operands (and keep
    // in_valid up a while for M ops, which must be ignored during RUN).
    task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int n;
        chk("model_pin", model(ins, a, b), exp);
        instruction = ins; src_A = a; src_B = b; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        chk("accept_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        src_A = $urandom; src_B = $urandom;
        if (latency(ins, a, b) > 0) begin
            repeat (5) @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (!out_valid && n < 60) begin @(posedge clk); #1; n++; end
        chk("result_timeout", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic run(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        issue(ins, a, b, exp);
        wait_result();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;
        @(posedge clk); #1;

        // Base operations
        run(r_ins(7'h00, 3'd0), 32'd5, 32'd7, 32'd12);
        run(r_ins(7'h20, 3'd0), 32'd5, 32'd7, 32'hFFFF_FFFE);
        run(r_ins(7'h00, 3'd1), 32'd1, 32'd35, 32'd8);
        run(r_ins(7'h20, 3'd5), 32'h8000_0000, 32'd4, 32'hF800_0000);
        run(r_ins(7'h00, 3'd5), 32'h8000_0000, 32'd4, 32'h0800_0000);
        run(r_ins(7'h00, 3'd2), 32'hFFFF_FFFF, 32'd1, 32'd1);
        run(r_ins(7'h00, 3'd3), 32'hFFFF_FFFF, 32'd1, 32'd0);
        run(r_ins(7'h00, 3'd4), 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        run(i_ins(7'h00, 3'd0), 32'd10, 32'hFFFF_FFFB, 32'd5);
        run(i_ins(7'h00, 3'd3), 32'd3, 32'hFFFF_FFFF, 32'd1);
        run(i_ins(7'h20, 3'd5), 32'h8000_0000, 32'h0000_0404, 32'hF800_0000);
        run(i_ins(7'h01, 3'd1), 32'd1, 32'h0000_0021, 32'd0);
        run({25'd0, 7'b0110111}, 32'd3, 32'd4, 32'd7);

        // Multiply
        run(r_ins(7'h01, 3'd0), 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run(r_ins(7'h01, 3'd3), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run(r_ins(7'h01, 3'd1), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        run(r_ins(7'h01, 3'd2), 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);

        // Divide, including special cases
        run(r_ins(7'h01, 3'd4), 32'd100, 32'd0, 32'hFFFF_FFFF);
        run(r_ins(7'h01, 3'd7), 32'd100, 32'd0, 32'd100);
        run(r_ins(7'h01, 3'd4), 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run(r_ins(7'h01, 3'd6), 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run(r_ins(7'h01, 3'd4), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run(r_ins(7'h01, 3'd6), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run(r_ins(7'h01, 3'd5), 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);
        run(r_ins(7'h01, 3'd7), 32'hFFFF_FFF9, 32'd2, 32'd1);

        // Back-to-back base ops with out_ready high
        for (int i = 0; i < 4; i++) begin
            chk("model_pin_b2b", model(r_ins(7'h00, 3'd0), 32'(i), 32'd100), 32'(100 + i));
            instruction = r_ins(7'h00, 3'd0); src_A = 32'(i); src_B = 32'd100; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Backpressure: result held, then new op accepted together with out_ready
        out_ready = 1'b0;
        issue(r_ins(7'h00, 3'd0), 32'd1, 32'd2, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(r_ins(7'h00, 3'd0), 32'd3, 32'd4, 32'd7);
        wait_result();

        // Reset during cycle 10 of a DIV; nothing stale may appear afterwards
        issue(r_ins(7'h01, 3'd4), 32'd1000, 32'd7, 32'd142);
        repeat (4) @(posedge clk);
        #1 n_rst = 1'b0;
        @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        run(r_ins(7'h01, 3'd6), 32'd1000, 32'd7, 32'd6);
        run(r_ins(7'h00, 3'd7), 32'hF0F0_F0F0, 32'h0FF0_FF00, 32'h00F0_F000);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
